// File: rtl/cnn_layer_feeder.sv
// Producer side of a single-layer CNN datapath: buffers image and filter samples, streams
// products into the layer, then strobes ReadEn and captures the layer's results in order.
module cnn_layer_feeder #(
    parameter int DW     = 10,
    parameter int RW     = 22,
    parameter int TAPS   = 3,
    parameter int N_OUT  = 5,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          img_we,
    input  logic [3:0]    img_addr,
    input  logic [DW-1:0] img_data,
    input  logic          flt_we,
    input  logic [1:0]    flt_addr,
    input  logic [DW-1:0] flt_data,
    input  logic          go,
    input  logic          abort,
    output logic          Start,
    output logic [DW-1:0] Image,
    output logic [DW-1:0] Filter,
    output logic          ReadEn,
    input  logic [RW-1:0] ConvResult,
    output logic          res_valid,
    output logic [RW-1:0] res_data,
    output logic [2:0]    res_idx,
    output logic          busy,
    output logic          done
);
    localparam int N_PROD = N_OUT * TAPS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PUSH  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [3:0]        prod_idx;
    logic [1:0]        tap_idx;
    logic [1:0]        tap_nx;
    logic [2:0]        rd_idx;
    logic [DW-1:0]     img_buf [16];
    logic [DW-1:0]     flt_buf [TAPS];
    logic [DW-1:0]     img_first;
    logic [DW-1:0]     flt_first;
    logic [RD_LAT-1:0] cap_vld;
    logic [2:0]        cap_idx [RD_LAT];
    logic              kill;

    assign kill   = abort && (state != S_IDLE);
    assign tap_nx = (tap_idx == 2'(TAPS - 1)) ? 2'd0 : tap_idx + 2'd1;

    // A buffer write landing in the go cycle must already show up in the first product.
    assign img_first = (img_we && img_addr == 4'd0) ? img_data : img_buf[0];
    assign flt_first = (flt_we && flt_addr == 2'd0) ? flt_data : flt_buf[0];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (go) state_nx = S_PUSH;
            S_PUSH:  if (prod_idx == 4'(N_PROD - 1)) state_nx = S_GAP;
            S_GAP:   state_nx = S_READ;
            S_READ:  if (rd_idx == 3'(N_OUT - 1)) state_nx = S_DRAIN;
            S_DRAIN: if (done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (kill) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) img_buf[i] <= '0;
            for (int i = 0; i < TAPS; i++) flt_buf[i] <= '0;
        end else if (state == S_IDLE) begin
            if (img_we) img_buf[img_addr] <= img_data;
            if (flt_we && int'(flt_addr) < TAPS) flt_buf[flt_addr] <= flt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Start    <= 1'b0;
            Image    <= '0;
            Filter   <= '0;
            ReadEn   <= 1'b0;
            prod_idx <= '0;
            tap_idx  <= '0;
            rd_idx   <= '0;
        end else if (kill) begin
            Start  <= 1'b0;
            Image  <= '0;
            Filter <= '0;
            ReadEn <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        Start    <= 1'b1;
                        Image    <= img_first;
                        Filter   <= flt_first;
                        prod_idx <= '0;
                        tap_idx  <= '0;
                    end
                end
                S_PUSH: begin
                    if (prod_idx == 4'(N_PROD - 1)) begin
                        Start  <= 1'b0;
                        Image  <= '0;
                        Filter <= '0;
                    end else begin
                        prod_idx <= prod_idx + 4'd1;
                        tap_idx  <= tap_nx;
                        Image    <= img_buf[prod_idx + 4'd1];
                        Filter   <= flt_buf[tap_nx];
                    end
                end
                S_GAP: begin
                    ReadEn <= 1'b1;
                    rd_idx <= '0;
                end
                S_READ: begin
                    if (rd_idx == 3'(N_OUT - 1)) ReadEn <= 1'b0;
                    else rd_idx <= rd_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Each ReadEn cycle travels down this pipe so its result is sampled RD_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld   <= '0;
            for (int i = 0; i < RD_LAT; i++) cap_idx[i] <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            done      <= 1'b0;
        end else if (kill) begin
            cap_vld   <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            cap_vld[0] <= ReadEn;
            cap_idx[0] <= rd_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                cap_vld[i] <= cap_vld[i-1];
                cap_idx[i] <= cap_idx[i-1];
            end
            res_valid <= cap_vld[RD_LAT-1];
            done      <= cap_vld[RD_LAT-1] && (cap_idx[RD_LAT-1] == 3'(N_OUT - 1));
            if (cap_vld[RD_LAT-1]) begin
                res_data <= ConvResult;
                res_idx  <= cap_idx[RD_LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_cnn_layer_feeder.sv
// Bench for cnn_layer_feeder: a table of run scenarios plus randomized runs, every cycle
// of a run compared against a cycle-numbered model of what one feeder run should look like.
module tb_cnn_layer_feeder;
    localparam int DW     = 10;
    localparam int RW     = 22;
    localparam int TAPS   = 3;
    localparam int N_OUT  = 5;
    localparam int RD_LAT = 2;
    localparam int N_PROD = N_OUT * TAPS;
    localparam int T_RD0  = N_PROD + 2;
    localparam int T_CAP0 = T_RD0 + RD_LAT + 1;
    localparam int T_LAST = T_CAP0 + N_OUT - 1;
    localparam int N_VEC  = 11;

    logic          clk;
    logic          rst_n;
    logic          img_we;
    logic [3:0]    img_addr;
    logic [DW-1:0] img_data;
    logic          flt_we;
    logic [1:0]    flt_addr;
    logic [DW-1:0] flt_data;
    logic          go;
    logic          abort;
    logic          Start;
    logic [DW-1:0] Image;
    logic [DW-1:0] Filter;
    logic          ReadEn;
    logic [RW-1:0] ConvResult;
    logic          res_valid;
    logic [RW-1:0] res_data;
    logic [2:0]    res_idx;
    logic          busy;
    logic          done;

    cnn_layer_feeder #(.DW(DW), .RW(RW), .TAPS(TAPS), .N_OUT(N_OUT), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
        .flt_we(flt_we), .flt_addr(flt_addr), .flt_data(flt_data),
        .go(go), .abort(abort),
        .Start(Start), .Image(Image), .Filter(Filter), .ReadEn(ReadEn),
        .ConvResult(ConvResult),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic          start;
        logic [DW-1:0] image;
        logic [DW-1:0] filter;
        logic          read_en;
        logic          res_valid;
        logic [RW-1:0] res_data;
        logic [2:0]    res_idx;
        logic          busy;
        logic          done;
    } obs_t;

    typedef struct {
        bit pattern;
        bit reload;
        int abort_at;
        int go_at;
        int wr_at;
        bit abort_with_go;
        bit wr_with_go;
        int exp_nres;
        int exp_done;
    } vec_t;

    logic [DW-1:0] img_m [16];
    logic [DW-1:0] flt_m [TAPS];
    logic [RW-1:0] vals_m [N_OUT];
    logic [RW-1:0] m_res_data;
    logic [2:0]    m_res_idx;
    int            total = 0;
    int            bad = 0;
    vec_t          vecs [N_VEC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk_vec(bit pattern, bit reload, int abort_at, int go_at, int wr_at,
                                    bit abort_with_go, bit wr_with_go, int exp_nres, int exp_done);
        vec_t v;
        v.pattern = pattern;       v.reload = reload;
        v.abort_at = abort_at;     v.go_at = go_at;       v.wr_at = wr_at;
        v.abort_with_go = abort_with_go; v.wr_with_go = wr_with_go;
        v.exp_nres = exp_nres;     v.exp_done = exp_done;
        return v;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o.start = Start;         o.image = Image;       o.filter = Filter;
        o.read_en = ReadEn;      o.res_valid = res_valid;
        o.res_data = res_data;   o.res_idx = res_idx;
        o.busy = busy;           o.done = done;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t e;
        e = '0;
        e.res_data = m_res_data;
        e.res_idx  = m_res_idx;
        return e;
    endfunction

    // Cycle t counts from 1 = first cycle after go was sampled.
    function automatic obs_t expect_cycle(input int t);
        obs_t e;
        int   j;
        e = idle_obs();
        if (t >= 1 && t <= T_LAST) e.busy = 1'b1;
        if (t >= 1 && t <= N_PROD) begin
            e.start  = 1'b1;
            e.image  = img_m[t-1];
            e.filter = flt_m[(t-1) % TAPS];
        end
        if (t >= T_RD0 && t < T_RD0 + N_OUT) e.read_en = 1'b1;
        j = t - T_CAP0;
        if (j >= 0 && j < N_OUT) begin
            e.res_valid = 1'b1;
            e.res_data  = vals_m[j];
            e.res_idx   = 3'(j);
            e.done      = (j == N_OUT - 1);
        end
        return e;
    endfunction

    task automatic check_output(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_count(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic set_bufs(input bit pattern);
        for (int i = 0; i < 16; i++) img_m[i] = pattern ? DW'(i + 1) : DW'($urandom);
        for (int i = 0; i < TAPS; i++) flt_m[i] = DW'($urandom);
        if (pattern) begin
            flt_m[0] = 10'd1;
            flt_m[1] = 10'h3FE;
            flt_m[2] = 10'd3;
        end
    endtask

    task automatic set_vals(input bit pattern);
        for (int j = 0; j < N_OUT; j++) vals_m[j] = pattern ? RW'(100 * j + 7) : RW'($urandom);
    endtask

    // Writes the model buffers through the bus, plus one write to the nonexistent tap 3.
    task automatic load_buffers();
        for (int i = 0; i < 16; i++) begin
            img_we = 1'b1; img_addr = 4'(i); img_data = img_m[i];
            @(negedge clk);
        end
        img_we = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            flt_we = 1'b1; flt_addr = 2'(i); flt_data = flt_m[i];
            @(negedge clk);
        end
        flt_addr = 2'd3; flt_data = DW'($urandom);
        @(negedge clk);
        flt_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
    task automatic apply_stimulus(input vec_t v, input string tag, output int nres, output int ndone);
        obs_t act;
        obs_t exp;
        bool_dummy: begin end
        nres = 0;
        ndone = 0;
        go = 1'b1;
        abort = v.abort_with_go;
        if (v.wr_with_go) begin
            img_we = 1'b1; img_addr = 4'd0; img_data = DW'($urandom);
            flt_we = 1'b1; flt_addr = 2'd0; flt_data = DW'($urandom);
            img_m[0] = img_data;
            flt_m[0] = flt_data;
        end
        ConvResult = RW'($urandom);
        for (int t = 1; t <= T_LAST + 1; t++) begin
            @(negedge clk);
            go = 1'b0; abort = 1'b0; img_we = 1'b0; flt_we = 1'b0;
            act = sample_dut();
            if (v.abort_at != 0 && t > v.abort_at) exp = idle_obs();
            else exp = expect_cycle(t);
            check_output($sformatf("%s_c%0d", tag, t), act, exp);
            if (act.res_valid) nres++;
            if (act.done) ndone++;
            if (exp.res_valid) begin
                m_res_data = exp.res_data;
                m_res_idx  = exp.res_idx;
            end
            if (v.abort_at != 0 && t > v.abort_at) break;
            if (t == v.abort_at) abort = 1'b1;
            if (t == v.go_at) go = 1'b1;
            if (t == v.wr_at) begin
                img_we = 1'b1; img_addr = 4'd0; img_data = 10'd999;
                flt_we = 1'b1; flt_addr = 2'd0; flt_data = DW'($urandom);
            end
            if (t >= T_RD0 + RD_LAT && t < T_RD0 + RD_LAT + N_OUT)
                ConvResult = vals_m[t - T_RD0 - RD_LAT];
            else
                ConvResult = RW'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   nres;
        int   ndone;
        int   ab;
        obs_t act;
        vec_t plain;

        rst_n = 1'b0; go = 1'b0; abort = 1'b0;
        img_we = 1'b0; img_addr = '0; img_data = '0;
        flt_we = 1'b0; flt_addr = '0; flt_data = '0;
        ConvResult = '0;
        m_res_data = '0; m_res_idx = '0;
        plain = mk_vec(0, 0, 0, 0, 0, 0, 0, N_OUT, 1);

        //                pat rel abort go  wr  ab+go wr+go nres done
        vecs[0]  = mk_vec(1,  1,  0,    0,  0,  0,    0,    5,   1);
        vecs[1]  = mk_vec(1,  0,  18,   0,  0,  0,    0,    0,   0);
        vecs[2]  = mk_vec(0,  1,  22,   0,  0,  0,    0,    3,   0);
        vecs[3]  = mk_vec(0,  1,  5,    0,  0,  0,    0,    0,   0);
        vecs[4]  = mk_vec(0,  1,  0,    7,  0,  0,    0,    5,   1);
        vecs[5]  = mk_vec(1,  1,  0,    0,  3,  0,    0,    5,   1);
        vecs[6]  = mk_vec(1,  0,  0,    0,  0,  1,    0,    5,   1);
        vecs[7]  = mk_vec(0,  1,  0,    0,  0,  0,    1,    5,   1);
        vecs[8]  = mk_vec(0,  0,  24,   0,  0,  0,    0,    5,   1);
        vecs[9]  = mk_vec(0,  0,  16,   0,  0,  0,    0,    0,   0);
        vecs[10] = mk_vec(0,  0,  0,    20, 0,  0,    0,    5,   1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_state", sample_dut(), idle_obs());

        // Load real data, start a run, then pull reset in the middle of the product stream.
        set_bufs(0);
        load_buffers();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        act = sample_dut();
        check_output("reset_mid_push", act, obs_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) img_m[i] = '0;
        for (int i = 0; i < TAPS; i++) flt_m[i] = '0;
        m_res_data = '0; m_res_idx = '0;
        set_vals(1);
        apply_stimulus(plain, "cleared", nres, ndone);
        check_count("cleared_nres", nres, N_OUT);

        for (int i = 0; i < N_VEC; i++) begin
            set_vals(vecs[i].pattern);
            if (vecs[i].reload) begin
                set_bufs(vecs[i].pattern);
                load_buffers();
            end
            apply_stimulus(vecs[i], $sformatf("v%0d", i), nres, ndone);
            check_count($sformatf("v%0d_nres", i), nres, vecs[i].exp_nres);
            check_count($sformatf("v%0d_done", i), ndone, vecs[i].exp_done);
        end

        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        check_output("abort_in_idle", sample_dut(), idle_obs());

        for (int r = 0; r < 20; r++) begin
            set_bufs(0);
            load_buffers();
            set_vals(0);
            vals_m[0] = '1;
            ab = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(T_LAST, 1));
            apply_stimulus(mk_vec(0, 1, ab, 0, 0, 0, 0, 0, 0), $sformatf("r%0d", r), nres, ndone);
            if (ab == 0) check_count($sformatf("r%0d_nres", r), nres, N_OUT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
